// File: rtl/mem_access_sequencer_if.sv
// Memory beat port between the MEM-stage sequencer and data memory.
// master: req/we/addr/wdata out, ack/rdata in; slave is the mirror.
interface mem_access_sequencer_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_sequencer.sv
// MEM-stage sequencer: scalar/vector beats over a req/ack port, hold/abort.
// Ports: clk, rst(async low), em_* EX/MEM, mem bus if, id/ie hazard, status.
module mem_access_sequencer #(
  parameter int LANES       = 3,
  parameter int LANE_BYTES  = 2,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   em_valid,
  input  logic                   em_mem_read,
  input  logic                   em_mem_write,
  input  logic                   em_vec,
  input  logic [31:0]            em_addr,
  input  logic [31:0]            em_wdata,
  input  logic [16*LANES-1:0]    em_wdata_v,
  mem_access_sequencer_if.master mem,
  input  logic [4:0]             id_rs1,
  input  logic [4:0]             id_rs2,
  input  logic [4:0]             ie_rd,
  input  logic                   ie_mem_read,
  output logic [31:0]            ld_data,
  output logic [16*LANES-1:0]    ld_data_v,
  output logic                   done,
  output logic                   hold_pipe,
  output logic                   lu_stall,
  output logic                   wb_suppress,
  output logic                   err
);
  localparam int BW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [3:0] TMO_LAST = 4'(ACK_TIMEOUT - 1);

  typedef enum logic {IDLE, BEAT} state_t;

  state_t              state_q, state_d;
  logic [BW-1:0]       beat_q, beat_d;
  logic [3:0]          tmo_q, tmo_d;
  logic [31:0]         ld_q;
  logic [16*LANES-1:0] ldv_q;
  logic                err_q;
  logic                access, last, abort, hold, rd_beat;
  int                  lane;

  assign access = em_valid & (em_mem_read | em_mem_write);
  assign last = em_vec ? (beat_q == BW'(LANES - 1))
                       : (beat_q == '0);
  assign lane = int'(beat_q) * 16;
  assign rd_beat = (state_q == BEAT) & mem.mem_ack & em_mem_read;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      tmo_q   <= '0;
      ld_q    <= '0;
      ldv_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      tmo_q   <= tmo_d;
      if (abort) err_q <= 1'b1;
      if (rd_beat) begin
        if (em_vec) ldv_q[lane +: 16] <= mem.mem_rdata[15:0];
        else        ld_q <= mem.mem_rdata;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    tmo_d         = tmo_q;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    done          = 1'b0;
    abort         = 1'b0;
    hold          = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (access) begin
          state_d = BEAT;
          beat_d  = '0;
          tmo_d   = '0;
          hold    = 1'b1;
        end
      end
      BEAT: begin
        mem.mem_req   = 1'b1;
        mem.mem_we    = em_mem_write;
        mem.mem_addr  = em_addr
                      + 32'(beat_q) * 32'(LANE_BYTES);
        mem.mem_wdata = em_vec
                      ? {16'b0, em_wdata_v[lane +: 16]}
                      : em_wdata;
        if (mem.mem_ack) begin
          if (last) begin
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            beat_d = beat_q + 1'b1;
            tmo_d  = '0;
            hold   = 1'b1;
          end
        end else if (tmo_q == TMO_LAST) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
          hold  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bypass the acked read beat so results are valid alongside done.
  always_comb begin
    ld_data   = ld_q;
    ld_data_v = ldv_q;
    if (rd_beat) begin
      if (em_vec) ld_data_v[lane +: 16] = mem.mem_rdata[15:0];
      else        ld_data = mem.mem_rdata;
    end
  end

  // Gated by rst so everything reads 0 while reset is asserted.
  assign hold_pipe   = rst & hold;
  assign lu_stall    = rst & ie_mem_read & (ie_rd != 5'd0)
                     & ((ie_rd == id_rs1) | (ie_rd == id_rs2))
                     & ~hold;
  assign wb_suppress = abort;
  assign err         = err_q;
endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer.
// Tasks per scenario, inline checks, one summary line.
module tb_mem_access_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        em_valid = 0, em_mem_read = 0, em_mem_write = 0, em_vec = 0;
  logic [31:0] em_addr = 0, em_wdata = 0;
  logic [47:0] em_wdata_v = 0;
  logic [4:0]  id_rs1 = 0, id_rs2 = 0, ie_rd = 0;
  logic        ie_mem_read = 0;
  logic [31:0] ld_data;
  logic [47:0] ld_data_v;
  logic        done, hold_pipe, lu_stall, wb_suppress, err;
  int          errors = 0;
  int          checks = 0;

  mem_access_sequencer_if bus ();

  mem_access_sequencer dut (
    .clk(clk), .rst(rst),
    .em_valid(em_valid), .em_mem_read(em_mem_read),
    .em_mem_write(em_mem_write), .em_vec(em_vec),
    .em_addr(em_addr), .em_wdata(em_wdata), .em_wdata_v(em_wdata_v),
    .mem(bus.master),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ie_rd(ie_rd),
    .ie_mem_read(ie_mem_read),
    .ld_data(ld_data), .ld_data_v(ld_data_v), .done(done),
    .hold_pipe(hold_pipe), .lu_stall(lu_stall),
    .wb_suppress(wb_suppress), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [7:0] got;
    got = {bus.mem_req, bus.mem_we, done, hold_pipe,
           lu_stall, wb_suppress, err, 1'b0};
    checks++;
    if (got !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl: got %h want 00", got);
    end
    checks++;
    if ({bus.mem_addr, bus.mem_wdata, ld_data} !== 96'h0) begin
      errors++;
      $display("FAIL reset_bus: addr %h wdata %h ld %h want 0",
               bus.mem_addr, bus.mem_wdata, ld_data);
    end
    checks++;
    if (ld_data_v !== 48'h0) begin
      errors++;
      $display("FAIL reset_ldv: got %h want 0", ld_data_v);
    end
  endtask

  task automatic test_scalar_load;
    em_valid = 1; em_mem_read = 1; em_mem_write = 0; em_vec = 0;
    em_addr = 32'h100; bus.mem_ack = 0; bus.mem_rdata = 0;
    #1;
    checks++;
    if ({hold_pipe, bus.mem_req} !== 2'b10) begin
      errors++;
      $display("FAIL sl_start: hold,req %b want 10", {hold_pipe, bus.mem_req});
    end
    tick;
    checks++;
    if ({bus.mem_req, bus.mem_we, hold_pipe, done} !== 4'b1010) begin
      errors++;
      $display("FAIL sl_beat: req,we,hold,done %b want 1010",
               {bus.mem_req, bus.mem_we, hold_pipe, done});
    end
    checks++;
    if (bus.mem_addr !== 32'h100) begin
      errors++;
      $display("FAIL sl_addr: got %h want 100", bus.mem_addr);
    end
    bus.mem_ack = 1; bus.mem_rdata = 32'hDEADBEEF;
    #1;
    checks++;
    if ({done, hold_pipe} !== 2'b10 || ld_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL sl_done: done,hold %b ld %h want 10 deadbeef",
               {done, hold_pipe}, ld_data);
    end
    tick;
    em_valid = 0; bus.mem_ack = 0; bus.mem_rdata = 0;
    #1;
    checks++;
    if ({done, bus.mem_req} !== 2'b00 || ld_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL sl_after: done,req %b ld %h want 00 deadbeef",
               {done, bus.mem_req}, ld_data);
    end
  endtask

  task automatic test_idle_ack;
    bus.mem_ack = 1; bus.mem_rdata = 32'h12345678;
    #1;
    checks++;
    if ({done, bus.mem_req, hold_pipe} !== 3'b000) begin
      errors++;
      $display("FAIL idle_ack: done,req,hold %b want 000",
               {done, bus.mem_req, hold_pipe});
    end
    tick;
    checks++;
    if (bus.mem_req !== 1'b0 || ld_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL idle_ack2: req %b ld %h want 0 deadbeef",
               bus.mem_req, ld_data);
    end
    bus.mem_ack = 0; bus.mem_rdata = 0;
  endtask

  task automatic test_vec_store;
    logic [31:0] wd [3];
    wd = '{32'h0000AAAA, 32'h0000BBBB, 32'h0000CCCC};
    em_valid = 1; em_mem_read = 0; em_mem_write = 1; em_vec = 1;
    em_addr = 32'h200; em_wdata_v = 48'hCCCC_BBBB_AAAA;
    em_wdata = 32'hFFFFFFFF;
    #1;
    checks++;
    if (hold_pipe !== 1'b1) begin
      errors++;
      $display("FAIL vs_start: hold %b want 1", hold_pipe);
    end
    for (int i = 0; i < 3; i++) begin
      tick;
      bus.mem_ack = 1;
      #1;
      checks++;
      if (bus.mem_addr !== 32'h200 + 32'(2 * i) ||
          bus.mem_wdata !== wd[i] || bus.mem_we !== 1'b1) begin
        errors++;
        $display("FAIL vs_beat%0d: addr %h wdata %h we %b want %h %h 1",
                 i, bus.mem_addr, bus.mem_wdata, bus.mem_we,
                 32'h200 + 32'(2 * i), wd[i]);
      end
      checks++;
      if (done !== (i == 2) || hold_pipe !== (i != 2)) begin
        errors++;
        $display("FAIL vs_done%0d: done %b hold %b want %b %b",
                 i, done, hold_pipe, i == 2, i != 2);
      end
    end
    tick;
    em_valid = 0; em_mem_write = 0; bus.mem_ack = 0;
    #1;
    checks++;
    if ({bus.mem_req, done} !== 2'b00) begin
      errors++;
      $display("FAIL vs_after: req,done %b want 00", {bus.mem_req, done});
    end
  endtask

  task automatic test_vec_load_wait;
    logic [31:0] rd [3];
    int b, ph;
    rd = '{32'hABCD1111, 32'hABCD2222, 32'hABCD3333};
    em_valid = 1; em_mem_read = 1; em_vec = 1; em_addr = 32'h300;
    #1;
    checks++;
    if (hold_pipe !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL vl_c0: hold %b done %b want 1 0", hold_pipe, done);
    end
    for (int c = 1; c <= 9; c++) begin
      tick;
      b = (c - 1) / 3;
      ph = (c - 1) % 3;
      bus.mem_ack = (ph == 2);
      bus.mem_rdata = rd[b];
      #1;
      checks++;
      if (hold_pipe !== (c != 9) || done !== (c == 9) ||
          bus.mem_addr !== 32'h300 + 32'(2 * b)) begin
        errors++;
        $display("FAIL vl_c%0d: hold %b done %b addr %h want %b %b %h",
                 c, hold_pipe, done, bus.mem_addr, c != 9, c == 9,
                 32'h300 + 32'(2 * b));
      end
    end
    checks++;
    if (ld_data_v !== 48'h3333_2222_1111) begin
      errors++;
      $display("FAIL vl_data: got %h want 333322221111", ld_data_v);
    end
    tick;
    em_valid = 0; em_mem_read = 0; bus.mem_ack = 0; bus.mem_rdata = 0;
    #1;
    checks++;
    if (ld_data_v !== 48'h3333_2222_1111 || done !== 1'b0) begin
      errors++;
      $display("FAIL vl_hold: ldv %h done %b want 333322221111 0",
               ld_data_v, done);
    end
  endtask

  task automatic test_load_use;
    logic [4:0] r1 [5], r2 [5], rd [5];
    logic       mr [5], exp [5];
    r1  = '{5'd3, 5'd5, 5'd0, 5'd5, 5'd7};
    r2  = '{5'd5, 5'd0, 5'd0, 5'd5, 5'd8};
    rd  = '{5'd5, 5'd5, 5'd0, 5'd5, 5'd9};
    mr  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    exp = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      id_rs1 = r1[i]; id_rs2 = r2[i]; ie_rd = rd[i]; ie_mem_read = mr[i];
      #1;
      checks++;
      if (lu_stall !== exp[i]) begin
        errors++;
        $display("FAIL lu_vec%0d: got %b want %b", i, lu_stall, exp[i]);
      end
    end
    id_rs1 = 5'd1; id_rs2 = 5'd5; ie_rd = 5'd5; ie_mem_read = 1;
    em_valid = 1; em_mem_read = 1; em_vec = 0; em_addr = 32'h40;
    #1;
    checks++;
    if ({hold_pipe, lu_stall} !== 2'b10) begin
      errors++;
      $display("FAIL lu_hold: hold,lu %b want 10", {hold_pipe, lu_stall});
    end
    tick;
    bus.mem_ack = 1; bus.mem_rdata = 32'h0BADF00D;
    #1;
    checks++;
    if ({done, lu_stall} !== 2'b11) begin
      errors++;
      $display("FAIL lu_done: done,lu %b want 11", {done, lu_stall});
    end
    tick;
    em_valid = 0; em_mem_read = 0; bus.mem_ack = 0;
    ie_mem_read = 0; ie_rd = 0; id_rs1 = 0; id_rs2 = 0;
  endtask

  task automatic test_timeout;
    em_valid = 1; em_mem_read = 1; em_vec = 0; em_addr = 32'h400;
    bus.mem_ack = 0;
    #1;
    for (int c = 1; c <= 15; c++) begin
      tick;
      checks++;
      if (hold_pipe !== (c != 15) || wb_suppress !== (c == 15) ||
          bus.mem_req !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
        errors++;
        $display("FAIL tmo_c%0d: hold %b sup %b req %b done %b err %b",
                 c, hold_pipe, wb_suppress, bus.mem_req, done, err);
      end
    end
    tick;
    em_valid = 0; em_mem_read = 0;
    #1;
    checks++;
    if ({err, wb_suppress, bus.mem_req} !== 3'b100) begin
      errors++;
      $display("FAIL tmo_after: err,sup,req %b want 100",
               {err, wb_suppress, bus.mem_req});
    end
    tick; tick;
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL tmo_sticky: err %b want 1", err);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd [3];
    rd = '{32'h00004444, 32'h00005555, 32'h00006666};
    em_valid = 1; em_mem_read = 1; em_vec = 1; em_addr = 32'h500;
    tick;
    bus.mem_ack = 1; bus.mem_rdata = 32'h00009999;
    tick;
    bus.mem_ack = 0;
    #1;
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h502) begin
      errors++;
      $display("FAIL rm_beat1: req %b addr %h want 1 502",
               bus.mem_req, bus.mem_addr);
    end
    rst = 0;
    #1;
    checks++;
    if ({bus.mem_req, hold_pipe, done, err} !== 4'b0000 ||
        ld_data_v !== 48'h0) begin
      errors++;
      $display("FAIL rm_async: req,hold,done,err %b ldv %h want 0000 0",
               {bus.mem_req, hold_pipe, done, err}, ld_data_v);
    end
    tick; tick;
    rst = 1;
    #1;
    checks++;
    if ({hold_pipe, bus.mem_req} !== 2'b10) begin
      errors++;
      $display("FAIL rm_restart: hold,req %b want 10",
               {hold_pipe, bus.mem_req});
    end
    for (int i = 0; i < 3; i++) begin
      tick;
      bus.mem_ack = 1; bus.mem_rdata = rd[i];
      #1;
      checks++;
      if (bus.mem_addr !== 32'h500 + 32'(2 * i) || done !== (i == 2)) begin
        errors++;
        $display("FAIL rm_beat%0d: addr %h done %b want %h %b", i,
                 bus.mem_addr, done, 32'h500 + 32'(2 * i), i == 2);
      end
    end
    checks++;
    if (ld_data_v !== 48'h6666_5555_4444) begin
      errors++;
      $display("FAIL rm_data: got %h want 666655554444", ld_data_v);
    end
    tick;
    em_valid = 0; em_mem_read = 0; bus.mem_ack = 0;
  endtask

  initial begin
    bus.mem_ack = 0;
    bus.mem_rdata = 0;
    #3;
    test_reset;
    @(posedge clk);
    #1;
    rst = 1;
    tick;
    test_scalar_load;
    test_idle_ack;
    test_vec_store;
    test_vec_load_wait;
    test_load_use;
    test_timeout;
    test_reset_mid;
    tick;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
